// File: rtl/de3cd_sysctrl_pkg.sv
// Shared types and constants for the de3cd system-controller AXI4-Lite register block.
package de3cd_sysctrl_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] reg_idx_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // Snapshot of both channel FSMs, handy for binding protocol checkers.
  typedef struct packed {
    w_state_e w_state;
    r_state_e r_state;
  } fsm_dbg_t;

endpackage

// File: rtl/de3cd_sysctrl_wstrb_merge.sv
// Byte-lane merge: lanes with wstrb set take wdata, the others keep old_data.
module de3cd_sysctrl_wstrb_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] new_data
);

  always_comb begin
    new_data = old_data;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) new_data[8*b +: 8] = wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/de3cd_sysctrl_axil_regs.sv
// AXI4-Lite responder for the four de3cd control registers at 0x0/0x4/0x8/0xC.
// Define DE3CD_SYSCTRL_ADDR_CHECK_EN to answer out-of-range addresses with SLVERR.
//
// Handshake rule on every channel: a beat transfers on a rising edge where
// VALID and READY are both high; VALID, once raised, holds its payload stable
// until that edge. All READY/VALID outputs here come straight from flops.
module de3cd_sysctrl_axil_regs
  import de3cd_sysctrl_pkg::*;
#(
  parameter int           C_S_AXI_DATA_WIDTH = 32,
  parameter int           C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [127:0] C_REG_RESET        = 128'h0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [127:0]                    reg_o,
  output logic [3:0]                      wr_pulse_o
);

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("de3cd_sysctrl_axil_regs supports only a 32-bit data bus");
  end

  logic [31:0] regs [NUM_REGS];

  w_state_e    w_state;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [3:0]  wr_pulse_q;
  reg_idx_t    aw_idx_q;
  logic        aw_oor_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  r_state_e    r_state;
  logic        arready_q, rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  fsm_dbg_t    fsm_dbg;
  assign fsm_dbg = '{w_state: w_state, r_state: r_state};

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID  && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  reg_idx_t aw_idx, ar_idx;
  assign aw_idx = reg_idx_t'(S_AXI_AWADDR[3:2]);
  assign ar_idx = reg_idx_t'(S_AXI_ARADDR[3:2]);

  logic aw_oor, ar_oor;
`ifdef DE3CD_SYSCTRL_ADDR_CHECK_EN
  assign aw_oor = (S_AXI_AWADDR >> 4) != '0;
  assign ar_oor = (S_AXI_ARADDR >> 4) != '0;
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Commit happens on the edge where the later of address/data arrives.
  logic        commit, c_oor;
  reg_idx_t    c_idx;
  logic [31:0] c_data, merged;
  logic [3:0]  c_strb;

  always_comb begin
    commit = 1'b0;
    c_idx  = aw_idx_q;
    c_oor  = aw_oor_q;
    c_data = w_data_q;
    c_strb = w_strb_q;
    unique case (w_state)
      W_IDLE: if (aw_hs && w_hs) begin
        commit = 1'b1;
        c_idx  = aw_idx;
        c_oor  = aw_oor;
        c_data = S_AXI_WDATA;
        c_strb = S_AXI_WSTRB;
      end
      W_HAVE_A: if (w_hs) begin
        commit = 1'b1;
        c_data = S_AXI_WDATA;
        c_strb = S_AXI_WSTRB;
      end
      W_HAVE_D: if (aw_hs) begin
        commit = 1'b1;
        c_idx  = aw_idx;
        c_oor  = aw_oor;
      end
      default: ;
    endcase
  end

  de3cd_sysctrl_wstrb_merge u_merge (
    .old_data (regs[c_idx]),
    .wdata    (c_data),
    .wstrb    (c_strb),
    .new_data (merged)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state    <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      aw_idx_q   <= '0;
      aw_oor_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= C_REG_RESET[32*i +: 32];
    end else begin
      wr_pulse_q <= '0;
      if (commit) begin
        if (!c_oor) begin
          regs[c_idx]       <= merged;
          wr_pulse_q[c_idx] <= 1'b1;
        end
        bresp_q   <= c_oor ? RESP_SLVERR : RESP_OKAY;
        bvalid_q  <= 1'b1;
        awready_q <= 1'b0;
        wready_q  <= 1'b0;
        w_state   <= W_RESP;
      end else begin
        unique case (w_state)
          W_IDLE: begin
            // Readies rise here on the first cycle out of reset.
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            if (aw_hs) begin
              aw_idx_q  <= aw_idx;
              aw_oor_q  <= aw_oor;
              awready_q <= 1'b0;
              w_state   <= W_HAVE_A;
            end else if (w_hs) begin
              w_data_q <= S_AXI_WDATA;
              w_strb_q <= S_AXI_WSTRB;
              wready_q <= 1'b0;
              w_state  <= W_HAVE_D;
            end
          end
          W_RESP: if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Reads sample regs before this edge's commit lands, so a same-edge write is not visible.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            rdata_q   <= ar_oor ? 32'h0 : regs[ar_idx];
            rresp_q   <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end
        end
        R_DATA: if (S_AXI_RREADY) begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
          r_state   <= R_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_o = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_o[32*i +: 32] = regs[i];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign wr_pulse_o    = wr_pulse_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, fsm_dbg};

endmodule

// File: tb/tb_de3cd_sysctrl_axil_regs.sv
// Directed self-checking bench for de3cd_sysctrl_axil_regs (default build, 4-bit address).
module tb_de3cd_sysctrl_axil_regs;

  localparam logic [127:0] RST_VAL = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_ABCD};
  localparam int           TMO     = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb, wr_pulse;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  de3cd_sysctrl_axil_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .C_REG_RESET        (RST_VAL)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_o         (reg_o),
    .wr_pulse_o    (wr_pulse)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives AW and W with independent start delays; BREADY held low for b_stall cycles after commit.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_stall,
                           input logic [3:0] exp_pulse, input logic [31:0] exp_word, input string tag);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    bready = (b_stall == 0);
    while (!(aw_done && w_done) && cyc < TMO) begin
      if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
      if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
      if (!(aw_done && w_done)) begin
        check({tag, "_bvalid_early"}, bvalid, 1'b0);
        check({tag, "_pulse_early"}, wr_pulse, 4'b0000);
      end
      cyc++;
    end
    check({tag, "_timeout"}, cyc < TMO, 1'b1);
    check({tag, "_pulse"}, wr_pulse, exp_pulse);
    check({tag, "_bvalid"}, bvalid, 1'b1);
    check({tag, "_bresp"}, bresp, 2'b00);
    check({tag, "_reg"}, reg_o[32*addr[3:2] +: 32], exp_word);
    for (int k = 0; k < b_stall; k++) begin
      @(posedge clk); #1;
      check({tag, "_stall_bvalid"}, bvalid, 1'b1);
      check({tag, "_stall_bresp"}, bresp, 2'b00);
      check({tag, "_stall_rdy"}, {awready, wready}, 2'b00);
      check({tag, "_stall_pulse"}, wr_pulse, 4'b0000);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_bdone"}, bvalid, 1'b0);
    check({tag, "_pulse_off"}, wr_pulse, 4'b0000);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp_data, input int r_stall,
                          input string tag);
    bit ar_hs = 0;
    int cyc = 0;
    logic [31:0] exp_d;
    exp_q.push_back(exp_data);
    rready  = (r_stall == 0);
    arvalid = 1'b1;
    araddr  = addr;
    while (!ar_hs && cyc < TMO) begin
      ar_hs = arvalid && arready;
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    check({tag, "_timeout"}, ar_hs, 1'b1);
    exp_d = exp_q.pop_front();
    check({tag, "_rvalid"}, rvalid, 1'b1);
    check({tag, "_rdata"}, rdata, exp_d);
    check({tag, "_rresp"}, rresp, 2'b00);
    for (int k = 0; k < r_stall; k++) begin
      @(posedge clk); #1;
      check({tag, "_stall_rvalid"}, rvalid, 1'b1);
      check({tag, "_stall_rdata"}, rdata, exp_d);
      check({tag, "_stall_arready"}, arready, 1'b0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rdone"}, rvalid, 1'b0);
    check({tag, "_arready_back"}, arready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_pulse", wr_pulse, 4'b0000);
    check("rst_resps", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_regs", reg_o, RST_VAL);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, 4'b0001, 32'h1, "wr0");
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0, 4'b0010, 32'h2, "wr1");
    axi_write(4'h8, 32'h3, 4'hF, 0, 0, 0, 4'b0100, 32'h3, "wr2");
    axi_write(4'hC, 32'h4, 4'hF, 0, 0, 0, 4'b1000, 32'h4, "wr3");
    axi_read(4'h0, 32'h1, 0, "rd0");
    axi_read(4'h4, 32'h2, 0, "rd1");
    axi_read(4'h8, 32'h3, 0, "rd2");
    axi_read(4'hC, 32'h4, 0, "rd3");

    axi_write(4'h4, 32'hDEADBEEF, 4'hF, 3, 0, 0, 4'b0010, 32'hDEADBEEF, "w_first");
    axi_read(4'h4, 32'hDEADBEEF, 0, "rd_w_first");

    axi_write(4'h8, 32'h11223344, 4'hF, 0, 0, 0, 4'b0100, 32'h11223344, "full2");
    axi_write(4'h8, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 4'b0100, 32'h11BB33DD, "strb0101");
    axi_read(4'h8, 32'h11BB33DD, 0, "rd_strb");

    axi_write(4'h0, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 4'b0001, 32'h1, "strb0");
    axi_read(4'h0, 32'h1, 0, "rd_strb0");

    axi_write(4'h7, 32'h0F0F0F0F, 4'hF, 0, 0, 0, 4'b0010, 32'h0F0F0F0F, "lowbits");
    axi_read(4'h5, 32'h0F0F0F0F, 0, "rd_lowbits");

    axi_write(4'hC, 32'hCAFEF00D, 4'hF, 0, 2, 5, 4'b1000, 32'hCAFEF00D, "stall_b");
    axi_read(4'hC, 32'hCAFEF00D, 5, "stall_r");

    // Same-edge read and write of reg2: read sees the old contents.
    exp_q.push_back(32'h11BB33DD);
    check("same_readies", {awready, wready, arready}, 3'b111);
    awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF; araddr = 4'h8;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_rvalid", rvalid, 1'b1);
    check("same_rdata_old", rdata, exp_q.pop_front());
    check("same_bvalid", bvalid, 1'b1);
    check("same_pulse", wr_pulse, 4'b0100);
    check("same_reg", reg_o[95:64], 32'h55);
    @(posedge clk); #1;
    check("same_done", {bvalid, rvalid}, 2'b00);
    axi_read(4'h8, 32'h55, 0, "rd_same_new");

    // Reset with address latched and data still pending.
    awaddr = 4'hC; awvalid = 1'b1;
    wdata = 32'h99999999; wstrb = 4'hF;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("mid_have_a", {awready, wready}, 2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_readies", {awready, wready, arready}, 3'b000);
    check("mid_rst_regs", reg_o, RST_VAL);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_post_readies", {awready, wready, arready}, 3'b111);
    check("mid_post_bvalid", bvalid, 1'b0);
    check("mid_post_pulse", wr_pulse, 4'b0000);
    check("mid_post_regs", reg_o, RST_VAL);

    axi_write(4'h0, 32'h77, 4'hF, 2, 0, 0, 4'b0001, 32'h77, "post_rst_wr");
    axi_read(4'h0, 32'h77, 0, "post_rst_rd");
    axi_read(4'hC, 32'h3333_0003, 0, "post_rst_rd3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/de3cd_sysctrl_axil_regs.md
# de3cd_sysctrl_axil_regs

AXI4-Lite responder holding the four 32-bit control registers of the de3cd system controller at offsets 0x0, 0x4, 0x8 and 0xC. It sits behind the S00_AXI port of the controller, answering the PS/VIP master's single-beat writes and reads. It drives the register contents and per-register write strobes to the controller fabric.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; bits [3:2] select the register, bits [1:0] are ignored.
- C_REG_RESET, 128'h0: reset values, concatenated {reg3, reg2, reg1, reg0}.

Ports:
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESET  in  1  reset, synchronous, active-high.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data channel.
- reg_o  out  128  register contents, {reg3, reg2, reg1, reg0}.
- wr_pulse_o  out  4  one-cycle pulse per register on each committed write.

## Operation
- Write path FSM states:
  - W_IDLE: AWREADY=1, WREADY=1.
  - W_HAVE_A: address latched; AWREADY=0.
  - W_HAVE_D: data and strobe latched; WREADY=0.
  - W_RESP: BVALID=1; both READYs are 0.
- Address and data are accepted independently in either order.
  - Both accepted at the same edge, or the second one arrives: commit.
  - Commit: byte lanes with WSTRB=1 update the selected register. wr_pulse_o[sel] pulses. State goes to W_RESP.
- W_RESP to W_IDLE on BVALID&&BREADY. Only one write is outstanding at a time.
- Read path:
  - R_IDLE: ARREADY=1. ARVALID moves the path to R_DATA. RDATA is registered from the selected register.
  - R_DATA: RVALID=1, ARREADY=0. Returns to R_IDLE on RREADY.
- Simultaneous read and commit to the same register: RDATA returns the pre-write value.
- WSTRB=0: the write is committed with no bytes changed. The pulse still fires and BRESP is OKAY.
- BRESP and RRESP are OKAY (2'b00) unless overridden under Configuration.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY = 0 while reset is high; they go to 1 on the first cycle after reset.
  - BVALID, RVALID, wr_pulse_o = 0; BRESP, RRESP = 2'b00; RDATA = 0.
  - reg_o = C_REG_RESET.
- Write latency: AW and W handshake at edge N. Register update, wr_pulse_o and BVALID are all visible after edge N+1 is not used: they are visible immediately after edge N.
- Split write: AW at edge N and W at edge N+k commit at edge N+k.
- Read latency: AR handshake at edge N. RVALID and RDATA are valid after edge N.
- Back-to-back reads: a new AR can be accepted at the edge following the RREADY handshake. Maximum throughput is one read per 2 cycles, and likewise one write per 2 cycles.
- BVALID/RDATA/RRESP stay stable while stalled (no READY).
- Reset asserted mid-transaction aborts the transaction; no commit happens. Pending B/R responses are dropped and registers return to C_REG_RESET.

## Configuration
- DE3CD_SYSCTRL_ADDR_CHECK_EN defined:
  - Any address with bits above [3:2] nonzero is out of range.
  - Out-of-range writes change no register, produce no pulse, and return BRESP=SLVERR (2'b10).
  - Out-of-range reads return RDATA=0 and RRESP=SLVERR.
- Macro undefined: upper address bits are ignored and the access aliases onto reg[addr[3:2]] with OKAY. For C_S_AXI_ADDR_WIDTH=4 the two modes are identical.

## Structure
- Package de3cd_sysctrl_pkg holds:
  - NUM_REGS=4.
  - Response constants RESP_OKAY and RESP_SLVERR.
  - Enum typedefs for the write and read FSM states.
  - Register index typedef logic [1:0].
- Sub-module de3cd_sysctrl_wstrb_merge: combinational byte-lane merge (old, wdata, wstrb → new). It is shared by all four registers.
- The rest is flat in de3cd_sysctrl_axil_regs.

## Test plan
- Reset: check every output against its listed reset value. Then write 1, 2, 3, 4 to 0x0/0x4/0x8/0xC and read back. Reads return 0x1..0x4 with OKAY, and wr_pulse_o pulses 0001, 0010, 0100, 1000.
- W three cycles before AW to 0x4, data 0xDEADBEEF: BVALID only after AW. reg1=0xDEADBEEF.
- Partial strobes: reg2=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 → reg2=0x11BB33DD.
- BREADY/RREADY held low 5 cycles: BVALID/RVALID and data are stable. No new AW/W/AR accepted until release.
- Read 0x8 and write 0x8 (0x55) at the same edge: RDATA is the old value, then a subsequent read returns 0x55.
- Reset asserted with AW latched and W pending: no register change. After reset, all READYs return to 1 and BVALID=0.
